// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the main-memory arbiter.
// Memory is word-addressed in 2-byte steps; a block spans 2*WORDS_PER_BLK bytes.
package mem_arbiter_pkg;
  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 16;
  localparam int WORDS_PER_BLK = 8;
  localparam int MEM_LAT       = 4;
  localparam int IDX_W         = $clog2(WORDS_PER_BLK);
  localparam int CNT_W         = IDX_W + 1;
  localparam int OFF_W         = $clog2(2 * WORDS_PER_BLK);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FILL_I = 2'd2,
    ST_FILL_D = 2'd3
  } state_e;

  function automatic addr_t blk_base(addr_t a);
    return {a[ADDR_W-1:OFF_W], OFF_W'(0)};
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Pipelined main-memory bus: one request per cycle, reads return MEM_LAT cycles later.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic  mem_en;
  logic  mem_wr;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;
  logic  mem_valid;

  modport master (output mem_en, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_valid);
  modport slave  (input mem_en, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_valid);
endinterface

// File: rtl/mem_arbiter_fill_seq.sv
// Block-fill sequencer: latches the block base, issues WORDS_PER_BLK reads back to back
// and counts returning words; receive counting overlaps the issue phase.
module mem_arbiter_fill_seq
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  addr_t            miss_addr_i,
  input  logic             active_i,
  input  logic             mem_valid_i,
  output logic             issue_o,
  output addr_t            addr_o,
  output logic             recv_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);
  addr_t            base_q, base_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;

  assign issue_o = active_i && (issue_cnt_q < CNT_W'(WORDS_PER_BLK));
  assign addr_o  = base_q + ADDR_W'({issue_cnt_q, 1'b0});
  assign recv_o  = active_i && mem_valid_i;
  assign idx_o   = recv_cnt_q[IDX_W-1:0];
  assign last_o  = recv_o && (recv_cnt_q == CNT_W'(WORDS_PER_BLK - 1));

  always_comb begin
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (start_i) begin
      base_d      = blk_base(miss_addr_i);
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issue_o) issue_cnt_d = issue_cnt_q + 1'b1;
      if (recv_o)  recv_cnt_d  = recv_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-fill, D-fill and write-through stores.
// Grants are only decided in IDLE, so every grant is separated by at least one idle cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_miss_i,
  input  addr_t            i_miss_addr_i,
  input  logic             d_miss_i,
  input  addr_t            d_miss_addr_i,
  input  logic             d_wr_i,
  input  addr_t            d_wr_addr_i,
  input  data_t            d_wr_data_i,
  mem_arbiter_if.master    mem,
  output data_t            fill_data_o,
  output logic [IDX_W-1:0] fill_idx_o,
  output logic             i_fill_we_o,
  output logic             d_fill_we_o,
  output logic             i_fill_done_o,
  output logic             d_fill_done_o,
  output logic             d_wr_ack_o
);
  state_e           state_q, state_d;
  logic             start;
  addr_t            miss_addr;
  logic             fill_active;
  logic             seq_issue, seq_recv, seq_last;
  addr_t            seq_addr;
  logic [IDX_W-1:0] seq_idx;

  assign fill_active = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);

  mem_arbiter_fill_seq u_fill_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .miss_addr_i (miss_addr),
    .active_i    (fill_active),
    .mem_valid_i (mem.mem_valid),
    .issue_o     (seq_issue),
    .addr_o      (seq_addr),
    .recv_o      (seq_recv),
    .idx_o       (seq_idx),
    .last_o      (seq_last)
  );

  always_comb begin
    state_d       = state_q;
    start         = 1'b0;
    miss_addr     = i_miss_addr_i;
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    fill_data_o   = '0;
    fill_idx_o    = '0;
    i_fill_we_o   = 1'b0;
    d_fill_we_o   = 1'b0;
    i_fill_done_o = 1'b0;
    d_fill_done_o = 1'b0;
    d_wr_ack_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_wr_i) begin
          state_d = ST_WRITE;
        end else if (d_miss_i) begin
          state_d   = ST_FILL_D;
          start     = 1'b1;
          miss_addr = d_miss_addr_i;
        end else if (i_miss_i) begin
          state_d = ST_FILL_I;
          start   = 1'b1;
        end
      end
      ST_WRITE: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = d_wr_addr_i;
        mem.mem_wdata = d_wr_data_i;
        d_wr_ack_o    = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_FILL_I, ST_FILL_D: begin
        // Returns arriving outside a fill state (e.g. after reset) are dropped here.
        mem.mem_en    = seq_issue;
        mem.mem_addr  = seq_issue ? seq_addr : '0;
        fill_data_o   = mem.mem_rdata;
        fill_idx_o    = seq_idx;
        i_fill_we_o   = (state_q == ST_FILL_I) && seq_recv;
        d_fill_we_o   = (state_q == ST_FILL_D) && seq_recv;
        i_fill_done_o = (state_q == ST_FILL_I) && seq_last;
        d_fill_done_o = (state_q == ST_FILL_D) && seq_last;
        if (seq_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes cycle-stamped expectations,
// a monitor pops and compares whatever the DUT presents on each falling edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
  addr_t i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0;
  data_t d_wr_data = '0;
  data_t fill_data;
  logic [IDX_W-1:0] fill_idx;
  logic  i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack;
  int    checks = 0, failures = 0, cyc = 0;

  mem_arbiter_if mem_bus();

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_i(i_miss), .i_miss_addr_i(i_miss_addr),
    .d_miss_i(d_miss), .d_miss_addr_i(d_miss_addr),
    .d_wr_i(d_wr), .d_wr_addr_i(d_wr_addr), .d_wr_data_i(d_wr_data),
    .mem(mem_bus),
    .fill_data_o(fill_data), .fill_idx_o(fill_idx),
    .i_fill_we_o(i_fill_we), .d_fill_we_o(d_fill_we),
    .i_fill_done_o(i_fill_done), .d_fill_done_o(d_fill_done),
    .d_wr_ack_o(d_wr_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic data_t mdata(addr_t a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory model: not reset, so reads in flight across a reset still return.
  logic [MEM_LAT-1:0] pv = '0;
  addr_t              pa [MEM_LAT];
  always @(posedge clk) begin
    pv    <= {pv[MEM_LAT-2:0], mem_bus.mem_en && !mem_bus.mem_wr};
    pa[0] <= mem_bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
  end
  assign mem_bus.mem_valid = pv[MEM_LAT-1];
  assign mem_bus.mem_rdata = pv[MEM_LAT-1] ? mdata(pa[MEM_LAT-1]) : '0;

  typedef struct { int cyc; logic wr; addr_t addr; data_t data; } mreq_t;
  typedef struct { int cyc; logic is_d; logic [IDX_W-1:0] idx; data_t data; } fill_t;
  typedef struct { int cyc; int kind; } pulse_t;  // kind: 0 i_done, 1 d_done, 2 wr_ack
  mreq_t  mq [$];
  fill_t  fq [$];
  pulse_t pq [$];

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(string nm, logic [79:0] act);
    checks++;
    failures++;
    $display("FAIL %s unexpected act=%h t=%0t", nm, act, $time);
  endtask

  function automatic logic [79:0] outs();
    return 80'({mem_bus.mem_en, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata,
                fill_data, fill_idx, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack});
  endfunction

  task automatic exp_fill(bit is_d, addr_t base, int g);
    for (int k = 0; k < WORDS_PER_BLK; k++) begin
      mq.push_back(mreq_t'{g + 1 + k, 1'b0, base + ADDR_W'(2 * k), '0});
      fq.push_back(fill_t'{g + 1 + MEM_LAT + k, is_d, IDX_W'(k), mdata(base + ADDR_W'(2 * k))});
    end
    pq.push_back(pulse_t'{g + WORDS_PER_BLK + MEM_LAT, is_d ? 1 : 0});
  endtask

  task automatic exp_wr(addr_t a, data_t d, int g);
    mq.push_back(mreq_t'{g + 1, 1'b1, a, d});
    pq.push_back(pulse_t'{g + 1, 2});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester: assert, hold until its done/ack pulse, drop in the following cycle.
  task automatic drive(int which, addr_t a, data_t d);
    bit seen = 1'b0;
    case (which)
      0:       begin i_miss = 1'b1; i_miss_addr = a; end
      1:       begin d_miss = 1'b1; d_miss_addr = a; end
      default: begin d_wr = 1'b1; d_wr_addr = a; d_wr_data = d; end
    endcase
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      case (which)
        0:       seen = i_fill_done;
        1:       seen = d_fill_done;
        default: seen = d_wr_ack;
      endcase
    end
    if (!seen) unexp("req_timeout", 80'(which));
    tick();
    case (which)
      0:       i_miss = 1'b0;
      1:       d_miss = 1'b0;
      default: d_wr = 1'b0;
    endcase
  endtask

  task automatic monitor();
    mreq_t  m;
    fill_t  f;
    pulse_t p;
    int     np, kind;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_en) begin
        if (mq.size() == 0)
          unexp("mem_req", {32'(cyc), 15'b0, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata});
        else begin
          m = mq.pop_front();
          chk("mem_req", {32'(cyc), 15'b0, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata},
                         {32'(m.cyc), 15'b0, m.wr, m.addr, m.data});
        end
      end
      if (i_fill_we && d_fill_we) unexp("both_we", 80'(cyc));
      if (i_fill_we || d_fill_we) begin
        if (fq.size() == 0)
          unexp("fill", {32'(cyc), 15'b0, d_fill_we, 13'b0, fill_idx, fill_data});
        else begin
          f = fq.pop_front();
          chk("fill", {32'(cyc), 15'b0, d_fill_we, 13'b0, fill_idx, fill_data},
                      {32'(f.cyc), 15'b0, f.is_d, 13'b0, f.idx, f.data});
        end
      end
      np = int'(i_fill_done) + int'(d_fill_done) + int'(d_wr_ack);
      if (np > 1) unexp("multi_pulse", 80'(cyc));
      if (np != 0) begin
        kind = i_fill_done ? 0 : (d_fill_done ? 1 : 2);
        if (pq.size() == 0) unexp("pulse", {32'(cyc), 48'(kind)});
        else begin
          p = pq.pop_front();
          chk("pulse", {32'(cyc), 48'(kind)}, {32'(p.cyc), 48'(p.kind)});
        end
      end
    end
  endtask

  initial begin
    int c;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), '0);
    rst_n = 1'b1;

    // Reset in the cycle word 3 of a D fill lands; late returns must be ignored.
    tick(); c = cyc;
    d_miss = 1'b1; d_miss_addr = 16'h0806;
    for (int k = 0; k < WORDS_PER_BLK; k++)
      mq.push_back(mreq_t'{c + 1 + k, 1'b0, 16'h0800 + ADDR_W'(2 * k), '0});
    for (int k = 0; k < 4; k++)
      fq.push_back(fill_t'{c + 5 + k, 1'b1, IDX_W'(k), mdata(16'h0800 + ADDR_W'(2 * k))});
    repeat (8) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0; d_miss = 1'b0;
    #1;
    chk("rst_async", outs(), '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) tick();

    // I miss, unaligned address.
    tick(); c = cyc;
    exp_fill(1'b0, 16'h1230, c);
    drive(0, 16'h1236, '0);
    tick();

    // Simultaneous D and I miss: D first, I after one idle cycle.
    tick(); c = cyc;
    exp_fill(1'b1, 16'h0040, c);
    exp_fill(1'b0, 16'h2000, c + 13);
    fork
      drive(1, 16'h0040, '0);
      drive(0, 16'h2000, '0);
    join
    tick();

    // Store beats a pending D miss.
    tick(); c = cyc;
    exp_wr(16'h0100, 16'hBEEF, c);
    exp_fill(1'b1, 16'h0450, c + 2);
    fork
      drive(2, 16'h0100, 16'hBEEF);
      drive(1, 16'h0456, '0);
    join
    tick();

    // Store during an I fill waits; second store follows after one idle cycle.
    tick(); c = cyc;
    exp_fill(1'b0, 16'h3000, c);
    exp_wr(16'h0200, 16'h1234, c + 13);
    exp_wr(16'h0202, 16'h5678, c + 15);
    fork
      drive(0, 16'h3000, '0);
      begin
        repeat (3) tick();
        drive(2, 16'h0200, 16'h1234);
        drive(2, 16'h0202, 16'h5678);
      end
    join
    tick();

    // Top-of-memory block.
    tick(); c = cyc;
    exp_fill(1'b1, 16'hFFF0, c);
    drive(1, 16'hFFF7, '0);

    repeat (10) tick();
    chk("mq_left", 80'(mq.size()), '0);
    chk("fq_left", 80'(fq.size()), '0);
    chk("pq_left", 80'(pq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
